// File: rtl/btn_repeat.sv
// btn_repeat: push-button front end producing single-cycle step strobes.
//   Synchronises and debounces one raw button, flags debounced press/release
//   edges, and (optionally) generates auto-repeat pulses while the button is
//   held: first repeat HOLD_TICKS sample ticks after the press, then one every
//   REPEAT_TICKS sample ticks.
//
// Build option:
//   BTN_AUTOREPEAT_EN  defined   -> hold/repeat FSM built, REPT/HELD active
//                      undefined -> no FSM; REPT = HELD = 0, PULSE = PRESS
//
// Ports:
//   CLK      in   system clock, all logic on the rising edge
//   RST      in   synchronous reset, active-high
//   BTNIN    in   raw asynchronous button, 1 = pressed
//   LEVEL    out  debounced button level
//   PRESS    out  one-cycle pulse in the first cycle of a debounced press
//   RELEASE  out  one-cycle pulse in the first cycle of a debounced release
//   REPT     out  one-cycle auto-repeat pulse (only on sample-tick cycles)
//   PULSE    out  PRESS | REPT, step strobe for counters
//   HELD     out  high while the FSM is in the REPEAT state
module btn_repeat #(
  parameter int unsigned SAMPLE_DIV   = 125000,
  parameter int unsigned DEBOUNCE_N   = 16,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTNIN,
  output logic LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic REPT,
  output logic PULSE,
  output logic HELD
);

  localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV);
  localparam int unsigned STAB_W = $clog2(DEBOUNCE_N + 1);

  // Reject unusable configurations at elaboration time.
  if (SAMPLE_DIV < 2 || DEBOUNCE_N == 0 || HOLD_TICKS == 0 || REPEAT_TICKS == 0) begin : g_bad_cfg
    $error("btn_repeat: invalid parameter set");
  end

  // Two-flop synchroniser; only sync is seen by the debouncer.
  logic sync_meta;
  logic sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= BTNIN;
      sync      <= sync_meta;
    end
  end

  // Free-running sample prescaler; tick marks the last count of each period.
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Debounce: LEVEL follows sync only after DEBOUNCE_N consecutive differing ticks.
  logic              level_r;
  logic              level_q;
  logic [STAB_W-1:0] stab;

  always_ff @(posedge CLK) begin
    if (RST) begin
      level_r <= 1'b0;
      level_q <= 1'b0;
      stab    <= '0;
    end else begin
      level_q <= level_r;
      if (tick) begin
        if (sync != level_r) begin
          // stab holds the count of differing ticks already seen
          if (stab == STAB_W'(DEBOUNCE_N - 1)) begin
            level_r <= sync;
            stab    <= '0;
          end else begin
            stab <= stab + STAB_W'(1);
          end
        end else begin
          stab <= '0;
        end
      end
    end
  end

  assign LEVEL   = level_r;
  assign PRESS   = level_r & ~level_q;
  assign RELEASE = ~level_r & level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RC_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned RC_W   = $clog2(RC_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t          state;
  logic [RC_W-1:0] rc;
  logic            rept_hit;

  // Repeat fires on the tick that completes the current interval; gating on
  // LEVEL lets a release win over a coincident repeat.
  always_comb begin
    rept_hit = 1'b0;
    if (tick && level_r) begin
      case (state)
        HOLD:    rept_hit = (rc == RC_W'(HOLD_TICKS - 1));
        REPEAT:  rept_hit = (rc == RC_W'(REPEAT_TICKS - 1));
        default: rept_hit = 1'b0;
      endcase
    end
  end

  // Hold/repeat state machine; rc counts sample ticks within the interval.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rc    <= '0;
    end else if (!level_r) begin
      state <= IDLE;
      rc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PRESS) begin
            state <= HOLD;
            rc    <= '0;
          end
        end
        HOLD: begin
          if (tick) begin
            if (rept_hit) begin
              state <= REPEAT;
              rc    <= '0;
            end else begin
              rc <= rc + RC_W'(1);
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rept_hit) begin
              rc <= '0;
            end else begin
              rc <= rc + RC_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          rc    <= '0;
        end
      endcase
    end
  end

  assign REPT  = rept_hit;
  assign HELD  = (state == REPEAT);
  assign PULSE = PRESS | rept_hit;
`else
  assign REPT  = 1'b0;
  assign HELD  = 1'b0;
  assign PULSE = PRESS;
`endif

endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: scoreboard bench for btn_repeat with SAMPLE_DIV=4,
// DEBOUNCE_N=3, HOLD_TICKS=5, REPEAT_TICKS=2. Stimulus pushes expected pulse
// events {cycle, PRESS/RELEASE/REPT/PULSE}; a monitor pops and compares them
// whenever any pulse output is high. cyc counts cycles since the last reset
// edge, so tick cycles are cyc % 4 == 3.
`timescale 1ns/1ps
module tb_btn_repeat;

  localparam int unsigned SAMPLE_DIV   = 4;
  localparam int unsigned DEBOUNCE_N   = 3;
  localparam int unsigned HOLD_TICKS   = 5;
  localparam int unsigned REPEAT_TICKS = 2;

  // Event codes: {PRESS, RELEASE, REPT, PULSE}
  localparam logic [3:0] EV_PRESS   = 4'b1001;
  localparam logic [3:0] EV_RELEASE = 4'b0100;
  localparam logic [3:0] EV_REPT    = 4'b0011;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic HELD_EXP = 1'b1;
`else
  localparam logic HELD_EXP = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RST   = 1'b1;
  logic BTNIN = 1'b1;
  logic LEVEL, PRESS, RELEASE, REPT, PULSE, HELD;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at;
    logic [3:0] ev;
  } exp_t;

  exp_t q[$];

  btn_repeat #(
    .SAMPLE_DIV  (SAMPLE_DIV),
    .DEBOUNCE_N  (DEBOUNCE_N),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .BTNIN  (BTNIN),
    .LEVEL  (LEVEL),
    .PRESS  (PRESS),
    .RELEASE(RELEASE),
    .REPT   (REPT),
    .PULSE  (PULSE),
    .HELD   (HELD)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Monitor: every cycle with a pulse output high consumes one expected event.
  always @(negedge CLK) begin
    logic [3:0] ev;
    exp_t       e;
    ev = {PRESS, RELEASE, REPT, PULSE};
    if (ev != 4'b0000) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got ev=%b at cyc=%0d, required no pulse", ev, cyc);
      end else begin
        e = q.pop_front();
        if (e.ev != ev || e.at != cyc) begin
          bad++;
          $display("FAIL pulse_event: got ev=%b at cyc=%0d, required ev=%b at cyc=%0d",
                   ev, cyc, e.ev, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the falling edge of cycle n; bounded in case cyc never gets there.
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 2000) begin
      @(negedge CLK);
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL wait_cyc: reached cyc=%0d, required %0d", cyc, n);
    end
  endtask

  // Called at a falling edge; holds RST for n rising edges, checking all outputs are 0.
  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
      check("reset_outputs", 32'({LEVEL, PRESS, RELEASE, REPT, PULSE, HELD}), 32'd0);
    end
    RST = 1'b0;
  endtask

  task automatic drain(input string name);
    check(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    // Phase 1: reset with button already down, then hold for 20+ ticks.
    // sync=1 from cyc 2; ticks 3,7,11 -> LEVEL at 12; repeats at 31 then every 8.
    q.push_back('{at: 12, ev: EV_PRESS});
`ifdef BTN_AUTOREPEAT_EN
    for (int k = 0; k < 9; k++) q.push_back('{at: 31 + 8 * k, ev: EV_REPT});
`endif
    q.push_back('{at: 96, ev: EV_RELEASE});
    do_reset(3);
    wait_cyc(1);
    check("level_after_reset", 32'(LEVEL), 32'd0);
    wait_cyc(11);
    check("level_before_3rd_tick", 32'(LEVEL), 32'd0);
    wait_cyc(12);
    check("level_rise", 32'(LEVEL), 32'd1);
    wait_cyc(31);
    check("held_in_hold", 32'(HELD), 32'd0);
    wait_cyc(32);
    check("held_after_first_rept", 32'(HELD), 32'(HELD_EXP));
    wait_cyc(84);
    BTNIN = 1'b0;
    wait_cyc(95);
    check("level_before_release", 32'(LEVEL), 32'd1);
    wait_cyc(96);
    check("level_fall", 32'(LEVEL), 32'd0);
    check("held_release_cycle", 32'(HELD), 32'(HELD_EXP));
    wait_cyc(97);
    check("held_after_release", 32'(HELD), 32'd0);
    wait_cyc(110);
    drain("phase1_events_done");

    // Phase 2: bounce lasting 2 ticks (8 cycles) -> nothing.
    do_reset(1);
    wait_cyc(1);
    BTNIN = 1'b1;
    wait_cyc(9);
    BTNIN = 1'b0;
    wait_cyc(12);
    check("bounce_level", 32'(LEVEL), 32'd0);
    wait_cyc(40);
    check("bounce_level_late", 32'(LEVEL), 32'd0);
    drain("phase2_events_done");

    // Phase 3: release during HOLD; LEVEL drops at 28, before the 5th hold tick (31).
    do_reset(1);
    q.push_back('{at: 12, ev: EV_PRESS});
    q.push_back('{at: 28, ev: EV_RELEASE});
    wait_cyc(1);
    BTNIN = 1'b1;
    wait_cyc(17);
    BTNIN = 1'b0;
    wait_cyc(27);
    check("hold_level", 32'(LEVEL), 32'd1);
    check("hold_held", 32'(HELD), 32'd0);
    wait_cyc(28);
    check("hold_release_level", 32'(LEVEL), 32'd0);
    wait_cyc(29);
    check("hold_idle_held", 32'(HELD), 32'd0);
    wait_cyc(60);
    drain("phase3_events_done");

    // Phase 4: reach REPEAT, then a 1-cycle reset; nothing may follow.
    do_reset(1);
    q.push_back('{at: 12, ev: EV_PRESS});
`ifdef BTN_AUTOREPEAT_EN
    q.push_back('{at: 31, ev: EV_REPT});
`endif
    wait_cyc(1);
    BTNIN = 1'b1;
    wait_cyc(33);
    check("repeat_held", 32'(HELD), 32'(HELD_EXP));
    BTNIN = 1'b0;
    drain("phase4_events_before_reset");
    do_reset(1);
    wait_cyc(60);
    check("post_reset_level", 32'(LEVEL), 32'd0);
    drain("phase4_events_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
